// File: rtl/matrix_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_alu_pkg
//  Description : Shared definitions for the matrix ALU: opcode encoding,
//                FSM state encoding, default geometry and MMULT accumulator
//                width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_alu_pkg;

    // 4-bit opcode space; every code is defined so no opcode is undefined.
    typedef enum logic [3:0] {
        OP_NOP     = 4'h0,
        OP_MMULT   = 4'h1,
        OP_MSCALAR = 4'h2,
        OP_MADD    = 4'h3,
        OP_MSUB    = 4'h4,
        OP_MTRANS  = 4'h5,
        OP_ADD     = 4'h6,
        OP_SUB     = 4'h7,
        OP_XOR     = 4'h8,
        OP_ARS     = 4'h9,
        OP_ALS     = 4'hA,
        OP_LRS     = 4'hB,
        OP_LLS     = 4'hC,
        OP_GT      = 4'hD,
        OP_LT      = 4'hE,
        OP_EQ      = 4'hF
    } op_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 16;

    // Width needed to sum n products of two w-bit values without overflow.
    function automatic int acc_w(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

endpackage : matrix_alu_pkg
`default_nettype wire

// File: rtl/matrix_mac_row.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_mac_row
//  Description : Combinational row multiplier. Produces one row of C = A*B
//                from one row of A and the whole of B: N dot products of
//                length N, each accumulated at full width and truncated to
//                the low W bits.
//  Ports       : i_a_row    [N*W-1:0]   row i of A, element k at [k*W +: W]
//                i_matrix_b [N*N*W-1:0] operand B, (k,j) at [(k*N+j)*W +: W]
//                o_c_row    [N*W-1:0]   row i of C, element j at [j*W +: W]
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_mac_row
    import matrix_alu_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = DEFAULT_W
) (
    input  logic [N*W-1:0]   i_a_row,
    input  logic [N*N*W-1:0] i_matrix_b,
    output logic [N*W-1:0]   o_c_row
);

    localparam int c_acc_w = acc_w(N, W);

    for (genvar j = 0; j < N; j++) begin : g_col
        logic [c_acc_w-1:0] w_acc;

        always_comb begin
            w_acc = '0;
            for (int k = 0; k < N; k++) begin
                w_acc = w_acc + (c_acc_w'(i_a_row[k*W +: W]) *
                                 c_acc_w'(i_matrix_b[(k*N+j)*W +: W]));
            end
        end

        // Result is defined modulo 2^W.
        assign o_c_row[j*W +: W] = w_acc[W-1:0];
    end

endmodule : matrix_mac_row
`default_nettype wire

// File: rtl/matrix_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_alu_seq
//  Description : Registered NxN matrix ALU with valid/ready handshakes on
//                input and output. Element-wise operations complete one
//                cycle after accept; MMULT is computed row-serially, one row
//                per cycle, through a single shared row multiplier.
//  Ports       : clk        clock, rising edge
//                rst        synchronous reset, active low
//                in_valid   operation presented
//                in_ready   ready to accept an operation (IDLE)
//                op         opcode (op_e)
//                matrix_a   operand A, (i,j) at [(i*N+j)*W +: W]
//                matrix_b   operand B, same packing
//                out_valid  matrix_c holds a completed result
//                out_ready  consumer accepts the result
//                matrix_c   result, same packing
//                busy       high in EXEC or DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_alu_seq
    import matrix_alu_pkg::*;
#(
    parameter int N          = DEFAULT_N,
    parameter int W          = DEFAULT_W,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [N*N*W-1:0] matrix_a,
    input  logic [N*N*W-1:0] matrix_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*N*W-1:0] matrix_c,
    output logic             busy
);

    localparam int c_row_w    = $clog2(N);
    localparam int c_row_bits = N * W;
    localparam int c_mat_bits = N * N * W;
    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(N - 1);

    state_e                r_state;
    state_e                w_state_nxt;
    op_e                   r_op;
    logic [c_mat_bits-1:0] r_a;
    logic [c_mat_bits-1:0] r_b;
    logic [c_mat_bits-1:0] r_c;
    logic [c_row_w-1:0]    r_row;

    logic                  w_accept;
    logic                  w_row_wr;
    logic                  w_full_wr;
    logic [c_row_bits-1:0] w_a_row;
    logic [c_row_bits-1:0] w_mac_row;
    logic [c_mat_bits-1:0] w_elem_res;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        w_row_wr    = 1'b0;
        w_full_wr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                busy = 1'b1;
                // Non-MMULT ops spend exactly one EXEC cycle and write the
                // whole result from the registered operands.
                if (r_op == OP_MMULT) begin
                    w_row_wr = 1'b1;
                    if (r_row == c_last_row) begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_full_wr   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op  <= OP_NOP;
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
            r_row <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= op_e'(op);
                r_a   <= matrix_a;
                r_b   <= matrix_b;
                r_row <= '0;
            end
            if (w_row_wr) begin
                r_c[r_row*c_row_bits +: c_row_bits] <= w_mac_row;
                r_row                               <= r_row + c_row_w'(1);
            end
            if (w_full_wr) begin
                r_c <= w_elem_res;
            end
        end
    end

    assign matrix_c = r_c;

    // ------------------------------------------------------------------
    // Row-serial multiplier, shared across all EXEC cycles
    // ------------------------------------------------------------------
    assign w_a_row = r_a[r_row*c_row_bits +: c_row_bits];

    matrix_mac_row #(
        .N (N),
        .W (W)
    ) u_mac_row (
        .i_a_row    (w_a_row),
        .i_matrix_b (r_b),
        .o_c_row    (w_mac_row)
    );

    // ------------------------------------------------------------------
    // Element-wise / scalar / transpose unit
    // ------------------------------------------------------------------
    always_comb begin : p_elem
        logic [W-1:0] w_ea;
        logic [W-1:0] w_eb;
        logic [W-1:0] w_scalar;
        logic [W-1:0] w_er;
        logic         w_gt;
        logic         w_lt;

        w_elem_res = '0;
        w_scalar   = r_b[W-1:0];
        w_ea       = '0;
        w_eb       = '0;
        w_er       = '0;
        w_gt       = 1'b0;
        w_lt       = 1'b0;

        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                w_ea = r_a[(i*N+j)*W +: W];
                w_eb = r_b[(i*N+j)*W +: W];
                if (SIGNED_CMP) begin
                    w_gt = $signed(w_ea) > $signed(w_eb);
                    w_lt = $signed(w_ea) < $signed(w_eb);
                end else begin
                    w_gt = w_ea > w_eb;
                    w_lt = w_ea < w_eb;
                end
                case (r_op)
                    OP_MSCALAR: w_er = w_ea * w_scalar;
                    OP_MADD:    w_er = w_ea + w_eb;
                    OP_MSUB:    w_er = w_ea - w_eb;
                    OP_MTRANS:  w_er = r_a[(j*N+i)*W +: W];
                    OP_ADD:     w_er = w_ea + w_scalar;
                    OP_SUB:     w_er = w_ea - w_scalar;
                    OP_XOR:     w_er = w_ea ^ w_scalar;
                    OP_ARS:     w_er = {w_ea[W-1], w_ea[W-1:1]};
                    OP_ALS:     w_er = {w_ea[W-2:0], 1'b0};
                    OP_LRS:     w_er = {1'b0, w_ea[W-1:1]};
                    OP_LLS:     w_er = {w_ea[W-2:0], 1'b0};
                    OP_GT:      w_er = W'(w_gt);
                    OP_LT:      w_er = W'(w_lt);
                    OP_EQ:      w_er = W'(w_ea == w_eb);
                    default:    w_er = '0;  // NOP; MMULT uses the row path
                endcase
                w_elem_res[(i*N+j)*W +: W] = w_er;
            end
        end
    end

endmodule : matrix_alu_seq
`default_nettype wire

// File: tb/tb_matrix_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_alu_seq
//  Description : Self-checking bench for matrix_alu_seq. Two instances run in
//                lockstep (unsigned and signed compare). Directed table,
//                mid-MMULT reset sequence and randomized ops against a
//                behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_alu_seq;
    import matrix_alu_pkg::*;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MW = N * N * W;

    typedef logic [MW-1:0] mat_t;

    typedef struct {
        logic [3:0] op;
        mat_t       a;
        mat_t       b;
        mat_t       exp_u;
        mat_t       exp_s;
        int         hold;
    } vec_t;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] op        = 4'h0;
    mat_t       matrix_a  = '0;
    mat_t       matrix_b  = '0;

    logic in_ready_u, out_valid_u, busy_u;
    logic in_ready_s, out_valid_s, busy_s;
    mat_t c_u, c_s;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    matrix_alu_seq #(.N(N), .W(W), .SIGNED_CMP(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .op(op), .matrix_a(matrix_a), .matrix_b(matrix_b),
        .out_valid(out_valid_u), .out_ready(out_ready), .matrix_c(c_u),
        .busy(busy_u)
    );

    matrix_alu_seq #(.N(N), .W(W), .SIGNED_CMP(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .op(op), .matrix_a(matrix_a), .matrix_b(matrix_b),
        .out_valid(out_valid_s), .out_ready(out_ready), .matrix_c(c_s),
        .busy(busy_s)
    );

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] el(input mat_t m, input int i, input int j);
        return m[(i*N+j)*W +: W];
    endfunction

    function automatic mat_t put(input mat_t m, input int i, input int j, input logic [W-1:0] v);
        mat_t r = m;
        r[(i*N+j)*W +: W] = v;
        return r;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m = put(m, i, j, W'($urandom));
        return m;
    endfunction

    task automatic chk(input string name, input mat_t act, input mat_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: plain integer arithmetic, then reduce modulo 2^W.
    function automatic mat_t model(input logic [3:0] o, input mat_t a, input mat_t b, input bit sgn);
        mat_t   c    = '0;
        longint full = longint'(1) << W;
        longint half = longint'(1) << (W - 1);
        longint x, y, s, sx, sy, r;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                x  = longint'(el(a, i, j));
                y  = longint'(el(b, i, j));
                s  = longint'(el(b, 0, 0));
                sx = (x >= half) ? x - full : x;
                sy = (y >= half) ? y - full : y;
                r  = 0;
                case (o)
                    4'h1: for (int k = 0; k < N; k++)
                              r += longint'(el(a, i, k)) * longint'(el(b, k, j));
                    4'h2: r = x * s;
                    4'h3: r = x + y;
                    4'h4: r = x - y;
                    4'h5: r = longint'(el(a, j, i));
                    4'h6: r = x + s;
                    4'h7: r = x - s;
                    4'h8: r = x ^ s;
                    4'h9: r = (x >> 1) + ((x >= half) ? half : 0);
                    4'hA: r = x * 2;
                    4'hB: r = x / 2;
                    4'hC: r = x * 2;
                    4'hD: r = sgn ? longint'(sx > sy) : longint'(x > y);
                    4'hE: r = sgn ? longint'(sx < sy) : longint'(x < y);
                    4'hF: r = longint'(x == y);
                    default: r = 0;
                endcase
                c = put(c, i, j, r[W-1:0]);
            end
        end
        return c;
    endfunction

    // One full transaction: accept, latency, result, hold stability, handshake.
    task automatic run_op(input logic [3:0] o, input mat_t a, input mat_t b,
                          input mat_t exp_u, input mat_t exp_s, input int hold);
        int   cnt;
        bit   busy_ok;
        mat_t snap_u;
        mat_t snap_s;
        @(negedge clk);
        chk("idle_state", MW'({in_ready_u, busy_u, out_valid_u, in_ready_s}), MW'(4'b1001));
        in_valid = 1'b1; op = o; matrix_a = a; matrix_b = b;
        @(negedge clk);
        // Operands change after accept; the DUT must ignore them.
        in_valid = 1'b0; op = 4'($urandom); matrix_a = rand_mat(); matrix_b = rand_mat();
        cnt = 0; busy_ok = 1'b1;
        while (!out_valid_u && cnt < 50) begin
            if (in_ready_u || !busy_u || in_ready_s || out_valid_s) busy_ok = 1'b0;
            out_ready = 1'($urandom);
            in_valid  = 1'($urandom);
            @(negedge clk);
            cnt++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("latency", MW'(cnt), MW'((o == 4'h1) ? N : 1));
        chk("busy_during_exec", MW'(busy_ok), MW'(1));
        chk("result_unsigned", c_u, exp_u);
        chk("result_signed", c_s, exp_s);
        snap_u = c_u; snap_s = c_s;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_stable", {c_u ^ snap_u} | {c_s ^ snap_s}, '0);
            chk("hold_valid", MW'({out_valid_u, out_valid_s, in_ready_u}), MW'(3'b110));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_handshake", MW'({out_valid_u, in_ready_u, out_valid_s, in_ready_s}), MW'(4'b0101));
    endtask

    vec_t tbl[10];

    initial begin
        mat_t a, b, e, es;

        // ---------------- directed table ----------------
        a = '0; b = '0; e = '0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            a = put(a, i, j, W'(i*4+j)); b = put(b, i, j, 16'h0001); e = put(e, i, j, W'(i*4+j+1));
        end
        tbl[0] = '{4'h3, a, b, e, e, 3};

        a = '0; b = '0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            if (i == j) a = put(a, i, j, 16'h0001);
            b = put(b, i, j, W'(16'h0100 + i*4 + j));
        end
        tbl[1] = '{4'h1, a, b, b, b, 1};

        a = '0; b = '0; e = '0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            b = put(b, i, j, 16'h0001); e = put(e, i, j, 16'hFFFF);
        end
        tbl[2] = '{4'h4, a, b, e, e, 0};

        a = '0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) a = put(a, i, j, 16'h0100);
        tbl[3] = '{4'h1, a, a, '0, '0, 0};

        a = put('0, 0, 0, 16'h8002); e = put('0, 0, 0, 16'hC001);
        tbl[4] = '{4'h9, a, '0, e, e, 0};

        a = put('0, 0, 0, 16'hFFFF); b = put('0, 0, 0, 16'h0001);
        tbl[5] = '{4'hD, a, b, put('0, 0, 0, 16'h0001), '0, 1};
        tbl[6] = '{4'hE, a, b, '0, put('0, 0, 0, 16'h0001), 0};

        a = '0; e = '0; es = '0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            a = put(a, i, j, W'(i*4+j)); e = put(e, i, j, W'(j*4+i)); es = put(es, i, j, 16'h0001);
        end
        tbl[7] = '{4'h5, a, '0, e, e, 0};
        tbl[8] = '{4'h0, a, a, '0, '0, 0};
        tbl[9] = '{4'hF, a, a, es, es, 2};

        // ---------------- reset state ----------------
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", MW'({out_valid_u, in_ready_u, busy_u, out_valid_s, in_ready_s}), MW'(5'b01001));
        chk("reset_matrix_c", c_u | c_s, '0);
        rst = 1'b1;

        for (int v = 0; v < 10; v++)
            run_op(tbl[v].op, tbl[v].a, tbl[v].b, tbl[v].exp_u, tbl[v].exp_s, tbl[v].hold);

        // ---------------- reset during MMULT row 2 ----------------
        @(negedge clk);
        in_valid = 1'b1; op = 4'h1; matrix_a = rand_mat(); matrix_b = rand_mat();
        @(negedge clk);               // accepted; row 0 pending
        in_valid = 1'b0;
        @(negedge clk);               // row 0 written
        @(negedge clk);               // row 1 written, row 2 pending
        chk("mid_mmult_not_valid", MW'({out_valid_u, busy_u}), MW'(2'b01));
        rst = 1'b0;
        @(negedge clk);
        chk("abort_state", MW'({out_valid_u, in_ready_u, busy_u, out_valid_s, in_ready_s}), MW'(5'b01001));
        chk("abort_matrix_c", c_u | c_s, '0);
        rst = 1'b1;
        a = rand_mat();
        run_op(4'h5, a, '0, model(4'h5, a, '0, 1'b0), model(4'h5, a, '0, 1'b1), 0);

        // ---------------- randomized ops vs model ----------------
        for (int t = 0; t < 150; t++) begin
            logic [3:0] o;
            o = 4'($urandom_range(0, 15));
            a = rand_mat();
            b = ($urandom_range(0, 3) == 0) ? a : rand_mat();
            run_op(o, a, b, model(o, a, b, 1'b0), model(o, a, b, 1'b1), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_matrix_alu_seq
`default_nettype wire

// File: doc/matrix_alu_seq.md
Name: matrix_alu_seq

Overview:
- Parametrised, registered matrix ALU for the matrix engine datapath. Operates on NxN matrices of W-bit elements.
- Adds a valid/ready handshake on both input and output, plus a multi-cycle row-serial matrix multiply.
- Sits between the operand register file and the writeback stage.
- Executes one operation at a time.

Parameters:
- N, 4, matrix dimension (NxN); legal 2..8.
- W, 16, element width in bits; legal 8..32.
- SIGNED_CMP, 0, 1 = GT/LT compare elements as two's-complement; 0 = unsigned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept an operation.
- op  in  4  opcode, from matrix_alu_pkg.
- matrix_a  in  N*N*W  operand A; element (i,j) at bits [(i*N+j)*W +: W].
- matrix_b  in  N*N*W  operand B; same packing as matrix_a.
- out_valid  out  1  matrix_c holds a completed result.
- out_ready  in  1  consumer accepts the result.
- matrix_c  out  N*N*W  result; same packing as matrix_a.
- busy  out  1  high in EXEC or DONE.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE; out_valid=0; matrix_c=0; row counter=0; in_ready=1 after reset. Reset mid-operation aborts it; no partial result is ever presented.
- Opcodes:
  - 0 NOP, 1 MMULT, 2 MSCALAR, 3 MADD, 4 MSUB, 5 MTRANS, 6 ADD, 7 SUB, 8 XOR.
  - 9 ARS, A ALS, B LRS, C LLS, D GT, E LT, F EQ.
- Per-opcode semantics:
  - MMULT: C = A·B.
  - MSCALAR, ADD, SUB, XOR: each A element combined with scalar b[0][0].
  - MADD, MSUB: element-wise.
  - MTRANS: C[i][j] = A[j][i].
  - ARS, ALS, LRS, LLS: shift by 1. ARS always sign-extends bit W-1.
  - GT, LT, EQ: produce 1 or 0 per element.
  - NOP: all-zero result.
- Width rules: all arithmetic is modulo 2^W (truncate, no saturation). MMULT accumulates N products in a 2W+clog2(N)-bit accumulator, then truncates to the low W bits.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture A, B and op. If op==MMULT, go to EXEC with row=0; otherwise write the full result into matrix_c at the same edge's successor and go to DONE.
  - EXEC: in_ready=0. Each cycle writes output row `row` of matrix_c, then increments row. After writing row N-1, go to DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready, clear out_valid and go to IDLE.
- Latency (accept edge = t):
  - Non-MMULT: out_valid high after edge t+1.
  - MMULT: row r written at edge t+1+r; out_valid high after edge t+N.
  - Throughput: a new operation is accepted no earlier than the cycle after the output handshake.
- Rows of matrix_c not yet rewritten during EXEC keep their previous value and are not observable (out_valid=0).
- matrix_c and out_valid are stable while out_valid && !out_ready.
- Operands are registered at accept. Changes on matrix_a, matrix_b or op after accept have no effect.
- in_valid while in_ready=0 is ignored; the producer must hold it.
- out_ready while out_valid=0 is ignored.

Decomposition:
- Package matrix_alu_pkg: 4-bit opcode enum (values above); default N and W localparams; the ACC_W function (2W+clog2(N)).
- Sub-module matrix_mac_row: computes one output row (N dot products of length N) from row i of A and all of B. It is instantiated once and reused across EXEC cycles.

Test Plan:
- Reset, then MADD with N=4, W=16, a[i][j]=i*4+j, b all 0x0001 -> after 1 cycle, out_valid=1 and c[i][j]=i*4+j+1. Hold out_ready=0 for 3 cycles -> matrix_c stable.
- MMULT, A=identity, B[i][j]=0x0100+i*4+j -> out_valid exactly N=4 cycles after accept, C==B, in_ready=0 throughout.
- Wrap checks:
  - MSUB, a all 0x0000, b all 0x0001 -> c all 0xFFFF.
  - MMULT, A all 0x0100 and B all 0x0100 -> c all 0x0000 (0x40000 truncated).
- ARS on a[0][0]=0x8002 -> c[0][0]=0xC001.
- GT, a[0][0]=0xFFFF, b[0][0]=0x0001 -> c[0][0]=1 with SIGNED_CMP=0, 0 with SIGNED_CMP=1.
- Start MMULT, drive rst=0 at EXEC row 2 -> next edge: out_valid=0, matrix_c=0, in_ready=1. A following MTRANS completes correctly.
